// File: rtl/fifo_wr_arb_pkg.sv
// Shared scheduler definitions: arbiter FSM state encoding and a clog2 helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_t : ARB (0) = searching for a grantee, GRANT (1) = grant held
//   clog2()     : ceiling log2, used for index and counter widths
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Circular first-one finder: first set bit of req at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none, stateless.
//
// Ports:
//   req   : request vector, one bit per requester
//   ptr   : search start index (must be < N)
//   idx   : index of the first set bit found from ptr onwards
//   found : at least one bit of req is set
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [W:0] pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (W+1)'(i);
      if (pos >= (W+1)'(N)) begin
        pos = pos - (W+1)'(N);
      end
      if (!found && req[pos[W-1:0]]) begin
        found = 1'b1;
        idx   = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter merging NREQ requester streams into one FIFO write port.
// Latency: one ARB cycle per grant handover; beats pass combinationally while granted.
// Backpressure: i_wr_ready low stalls the grantee (ready deasserted), grant and beat count hold.
//
// Ports:
//   i_clk, i_rst_n  : clock and asynchronous active-low reset
//   i_req_data      : NREQ packed words, requester k at [k*DATW +: DATW]
//   i_req_valid     : per-requester word valid
//   i_req_last      : per-requester last word of burst (qualified by valid)
//   o_req_ready     : per-requester accept, only the grantee can see it high
//   o_wr_data/o_wr_en/i_wr_ready : FIFO write side
//   o_gnt_id, o_busy: current grantee index and grant-held flag
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DATW = 128,
  parameter int MAXB = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NREQ*DATW-1:0]     i_req_data,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ-1:0]          i_req_last,
  output logic [NREQ-1:0]          o_req_ready,
  output logic [DATW-1:0]          o_wr_data,
  output logic                     o_wr_en,
  input  logic                     i_wr_ready,
  output logic [clog2(NREQ)-1:0]   o_gnt_id,
  output logic                     o_busy
);

  localparam int GW = clog2(NREQ);
  localparam int CW = clog2(MAXB);

  arb_state_t      state_q;
  arb_state_t      state_d;
  logic [GW-1:0]   rr_ptr_q;
  logic [GW-1:0]   gnt_q;
  logic [CW-1:0]   beat_cnt_q;

  logic [GW-1:0]   pick_idx;
  logic            pick_found;
  logic [GW-1:0]   rr_next;
  logic            beat;
  logic            last_beat;

  rr_pick #(
    .N (NREQ),
    .W (GW)
  ) u_rr_pick (
    .req   (i_req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Pointer moves past the new grantee so it gets lowest priority next round.
  assign rr_next = (pick_idx == GW'(NREQ-1)) ? '0 : pick_idx + 1'b1;

  // A beat is any cycle the FIFO actually takes a word.
  assign beat = o_wr_en;

  // Grant ends on the burst's last word or when the MAXB-th beat lands;
  // a truncated burst simply continues in a later grant.
  assign last_beat = beat && (i_req_last[gnt_q] || (beat_cnt_q == CW'(MAXB-1)));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB: begin
        if (pick_found) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (last_beat) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (combinational from registered grant)
  // ---------------------------------------------------------------------------
  always_comb begin
    o_wr_en     = 1'b0;
    o_req_ready = '0;
    o_wr_data   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_q == GW'(k)) begin
        o_wr_data = i_req_data[k*DATW +: DATW];
      end
    end
    if (state_q == GRANT) begin
      o_wr_en             = i_req_valid[gnt_q] & i_wr_ready;
      o_req_ready[gnt_q]  = i_wr_ready;
    end
  end

  assign o_busy   = (state_q == GRANT);
  assign o_gnt_id = gnt_q;

  // ---------------------------------------------------------------------------
  // Grant bookkeeping: grantee, round-robin pointer, beat counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else if ((state_q == ARB) && pick_found) begin
      gnt_q      <= pick_idx;
      rr_ptr_q   <= rr_next;
      beat_cnt_q <= '0;
    end else if (beat) begin
      // Wraps to zero at MAXB; the grant is released on that same beat.
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int DATW = 32;
  localparam int MAXB = 16;
  localparam int GW   = 2;
  localparam int BIG  = 1 << 30;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic [NREQ*DATW-1:0] i_req_data;
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ-1:0]      i_req_last;
  logic [NREQ-1:0]      o_req_ready;
  logic [DATW-1:0]      o_wr_data;
  logic                 o_wr_en;
  logic                 i_wr_ready;
  logic [GW-1:0]        o_gnt_id;
  logic                 o_busy;

  always #5 i_clk = ~i_clk;

  fifo_wr_arb #(
    .NREQ (NREQ),
    .DATW (DATW),
    .MAXB (MAXB)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_data  (i_req_data),
    .i_req_valid (i_req_valid),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_wr_data   (o_wr_data),
    .o_wr_en     (o_wr_en),
    .i_wr_ready  (i_wr_ready),
    .o_gnt_id    (o_gnt_id),
    .o_busy      (o_busy)
  );

  typedef struct {
    logic [DATW-1:0] d;
    logic            last;
  } word_t;

  typedef struct {
    logic [NREQ-1:0] mask;
    logic [GW-1:0]   gnt;
  } vec_t;

  int              tests = 0;
  int              fails = 0;
  word_t           src_q[NREQ][$];
  logic [DATW-1:0] exp_q[NREQ][$];
  int              seqn[NREQ];
  logic [NREQ-1:0] hold;
  int              fifo_cnt;
  int              fifo_cap;
  logic            s_busy, s_wr_en, prev_busy;
  logic [GW-1:0]   s_gnt;
  logic [NREQ-1:0] s_rdy;
  int              glog_id[$];
  int              glog_beats[$];
  int              eid[8];
  int              ebt[8];
  vec_t            tbl[10];
  int              ncyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      if (src_q[k].size() > 0) begin
        i_req_valid[k]               = !hold[k];
        i_req_data[k*DATW +: DATW]   = src_q[k][0].d;
        i_req_last[k]                = src_q[k][0].last;
      end else begin
        i_req_valid[k]               = 1'b0;
        i_req_data[k*DATW +: DATW]   = '0;
        i_req_last[k]                = 1'b0;
      end
    end
  endtask

  // Queue a burst for requester k; the same words go to the scoreboard.
  task automatic push_burst(input int k, input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.d    = {8'(k), 24'(seqn[k])};
      w.last = (i == n - 1);
      seqn[k]++;
      src_q[k].push_back(w);
      exp_q[k].push_back(w.d);
    end
    drive();
  endtask

  // One clock: sample at negedge, check beats, advance sources after posedge.
  task automatic cycle();
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] exp_rdy;
    @(negedge i_clk);
    s_busy  = o_busy;
    s_wr_en = o_wr_en;
    s_gnt   = o_gnt_id;
    s_rdy   = o_req_ready;
    acc     = o_req_ready & i_req_valid;
    if (o_busy && !prev_busy) begin
      glog_id.push_back(int'(o_gnt_id));
      glog_beats.push_back(0);
    end
    prev_busy = o_busy;
    exp_rdy = '0;
    if (o_busy && i_wr_ready) exp_rdy[o_gnt_id] = 1'b1;
    chk("ready_map", o_req_ready, exp_rdy);
    chk("wr_en_vs_accept", o_wr_en, |acc);
    for (int k = 0; k < NREQ; k++) begin
      if (acc[k]) begin
        if (exp_q[k].size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          chk("beat_data", o_wr_data, exp_q[k].pop_front());
        end
        if (glog_beats.size() > 0) glog_beats[glog_beats.size()-1] += 1;
        fifo_cnt++;
      end
    end
    @(posedge i_clk);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    end
    i_wr_ready = (fifo_cnt < fifo_cap);
    drive();
  endtask

  task automatic drain(output int n);
    logic pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < 300) begin
      cycle();
      n++;
      pending = o_busy;
      for (int k = 0; k < NREQ; k++) if (src_q[k].size() > 0) pending = 1'b1;
    end
    if (pending) chk("drain_timeout", 1, 0);
    for (int k = 0; k < NREQ; k++) chk("scoreboard_empty", exp_q[k].size(), 0);
  endtask

  task automatic clear_all();
    for (int k = 0; k < NREQ; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    glog_id.delete();
    glog_beats.delete();
    hold      = '0;
    fifo_cnt  = 0;
    fifo_cap  = BIG;
    prev_busy = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    i_rst_n    = 1'b0;
    i_wr_ready = 1'b1;
    clear_all();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_ready", o_req_ready, 0);
    chk("rst_gnt", o_gnt_id, 0);
    i_rst_n = 1'b1;
  endtask

  task automatic chk_log(input string name, input int n);
    chk({name, "_ngrants"}, glog_id.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < glog_id.size()) begin
        chk({name, "_gnt_id"}, glog_id[i], eid[i]);
        chk({name, "_gnt_beats"}, glog_beats[i], ebt[i]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) seqn[k] = 0;
    i_req_data  = '0;
    i_req_valid = '0;
    i_req_last  = '0;

    // Single-word bursts from various masks; expected first grantee follows
    // the round-robin pointer left by the previous row.
    tbl[0] = '{4'b0001, 2'd0};
    tbl[1] = '{4'b0001, 2'd0};
    tbl[2] = '{4'b1001, 2'd3};
    tbl[3] = '{4'b0110, 2'd1};
    tbl[4] = '{4'b0111, 2'd0};
    tbl[5] = '{4'b1111, 2'd3};
    tbl[6] = '{4'b0100, 2'd2};
    tbl[7] = '{4'b0011, 2'd0};
    tbl[8] = '{4'b1010, 2'd3};
    tbl[9] = '{4'b0010, 2'd1};

    do_reset();
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < NREQ; k++) if (tbl[t].mask[k]) push_burst(k, 1);
      cycle();
      chk("tbl_arb_idle", s_busy, 0);
      cycle();
      chk("tbl_busy", s_busy, 1);
      chk("tbl_gnt", s_gnt, tbl[t].gnt);
      chk("tbl_wr_en", s_wr_en, 1);
      drain(ncyc);
    end

    // Single requester, three words: one ARB cycle then three back-to-back beats.
    do_reset();
    push_burst(0, 3);
    cycle();
    chk("single_arb", s_busy, 0);
    chk("single_arb_en", s_wr_en, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("single_beat_en", s_wr_en, 1);
      chk("single_gnt", s_gnt, 0);
    end
    cycle();
    chk("single_back_arb", s_busy, 0);

    // Four requesters, 2-beat bursts, requester 0 has two bursts queued.
    do_reset();
    for (int k = 0; k < NREQ; k++) push_burst(k, 2);
    push_burst(0, 2);
    drain(ncyc);
    chk("rr4_cycles", ncyc, 15);
    eid = '{0, 1, 2, 3, 0, 0, 0, 0};
    ebt = '{2, 2, 2, 2, 2, 0, 0, 0};
    chk_log("rr4", 5);

    // 40-word burst truncated at MAXB, interleaved with requester 3.
    do_reset();
    push_burst(2, 40);
    push_burst(3, 2);
    push_burst(3, 2);
    drain(ncyc);
    chk("maxb_cycles", ncyc, 49);
    eid = '{2, 3, 2, 3, 2, 0, 0, 0};
    ebt = '{16, 2, 16, 2, 8, 0, 0, 0};
    chk_log("maxb", 5);

    // FIFO of depth 4 fills mid-burst; stall must not advance the beat count.
    do_reset();
    fifo_cap = 4;
    push_burst(0, 20);
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("full_fill_en", s_wr_en, 1);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("full_stall_en", s_wr_en, 0);
      chk("full_stall_rdy", s_rdy, 0);
      chk("full_stall_busy", s_busy, 1);
      chk("full_stall_gnt", s_gnt, 0);
    end
    fifo_cnt   = 0;
    fifo_cap   = BIG;
    i_wr_ready = 1'b1;
    drain(ncyc);
    eid = '{0, 0, 0, 0, 0, 0, 0, 0};
    ebt = '{16, 4, 0, 0, 0, 0, 0, 0};
    chk_log("full", 2);

    // Grantee drops valid mid-burst: grant is held with no beats.
    do_reset();
    push_burst(0, 4);
    push_burst(1, 1);
    repeat (3) cycle();
    hold[0] = 1'b1;
    drive();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_busy", s_busy, 1);
      chk("hold_gnt", s_gnt, 0);
      chk("hold_en", s_wr_en, 0);
    end
    hold = '0;
    drive();
    drain(ncyc);
    eid = '{0, 1, 0, 0, 0, 0, 0, 0};
    ebt = '{4, 1, 0, 0, 0, 0, 0, 0};
    chk_log("hold", 2);

    // Reset asserted during beat 5; outputs drop at once, pointer restarts at 0.
    do_reset();
    push_burst(2, 10);
    repeat (5) cycle();
    #2;
    chk("rstmid_pre_en", o_wr_en, 1);
    chk("rstmid_pre_gnt", o_gnt_id, 2);
    i_rst_n = 1'b0;
    #1;
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_en", o_wr_en, 0);
    chk("rstmid_rdy", o_req_ready, 0);
    chk("rstmid_gnt", o_gnt_id, 0);
    clear_all();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    push_burst(1, 1);
    push_burst(3, 1);
    cycle();
    chk("rstmid_arb", s_busy, 0);
    cycle();
    chk("rstmid_first_gnt", s_gnt, 1);
    drain(ncyc);
    eid = '{1, 3, 0, 0, 0, 0, 0, 0};
    ebt = '{1, 1, 0, 0, 0, 0, 0, 0};
    chk_log("rstmid", 2);

    // New requesters appear on the grantee's last beat; next grant follows rr_ptr.
    do_reset();
    push_burst(1, 2);
    cycle();
    cycle();
    push_burst(0, 1);
    push_burst(3, 1);
    drain(ncyc);
    eid = '{1, 3, 0, 0, 0, 0, 0, 0};
    ebt = '{2, 1, 1, 0, 0, 0, 0, 0};
    chk_log("late", 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
